// File: rtl/regfile_pkg.sv
// Register-file geometry shared with register_file, plus the writeback slot
// entry type and the grant-selection helper used by the write arbiter.
package regfile_pkg;
    localparam int XLEN      = 32;
    localparam int REG_NUM_W = 5;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic [REG_NUM_W-1:0] reg_num;
        logic [XLEN-1:0]      val;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ0 = 2'd1,
        GNT_REQ1 = 2'd2
    } grant_e;

    // Same-register pairs drain oldest-first so the later value lands last;
    // otherwise alternate away from whoever was granted last.
    function automatic grant_e pick_grant(
        input logic full0,
        input logic full1,
        input logic same_reg,
        input logic younger0,
        input logic younger1,
        input logic last_req1
    );
        grant_e g;
        g = GNT_NONE;
        if (full0 && full1) begin
            if (same_reg) begin
                g = (younger0 && !younger1) ? GNT_REQ1 : GNT_REQ0;
            end else begin
                g = last_req1 ? GNT_REQ0 : GNT_REQ1;
            end
        end else if (full0) begin
            g = GNT_REQ0;
        end else if (full1) begin
            g = GNT_REQ1;
        end
        return g;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// One-entry writeback buffer; ready while empty or being granted, so a
// granted slot refills on the same edge. Register 0 is accepted and dropped.
module wb_slot
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [REG_NUM_W-1:0] req_reg_num,
    input  logic [XLEN-1:0]      req_val,
    output logic                 req_ready,
    input  logic                 grant,
    input  logic                 peer_hold,
    input  logic                 peer_grant,
    output logic                 full,
    output wb_entry_t            entry,
    output logic                 younger,
    input  logic [REG_NUM_W-1:0] query_a,
    input  logic [REG_NUM_W-1:0] query_b,
    output logic                 match_a,
    output logic                 match_b
);
    logic accept;

    assign req_ready = !full || grant;
    assign accept    = req_valid && req_ready;

    // younger marks an entry captured while the peer already held one that
    // survives the same edge; it clears once the peer drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 1'b0;
            entry   <= '0;
            younger <= 1'b0;
        end else if (accept) begin
            full          <= (req_reg_num != '0);
            entry.reg_num <= req_reg_num;
            entry.val     <= req_val;
            younger       <= peer_hold && (req_reg_num != '0);
        end else if (grant) begin
            full    <= 1'b0;
            younger <= 1'b0;
        end else if (peer_grant) begin
            younger <= 1'b0;
        end
    end

    assign match_a = full && (query_a != '0) && (entry.reg_num == query_a);
    assign match_b = full && (query_b != '0) && (entry.reg_num == query_b);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges two writeback streams onto the single register-file write port; the
// write is registered one edge after the grant, and each requester stalls only while its slot is full and not granted.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req0_valid,
    input  logic [REG_NUM_W-1:0] i_req0_reg_num,
    input  logic [XLEN-1:0]      i_req0_val,
    output logic                 o_req0_ready,
    input  logic                 i_req1_valid,
    input  logic [REG_NUM_W-1:0] i_req1_reg_num,
    input  logic [XLEN-1:0]      i_req1_val,
    output logic                 o_req1_ready,
    output logic                 o_w_en,
    output logic [REG_NUM_W-1:0] o_w_reg_num,
    output logic [XLEN-1:0]      o_w_val,
    input  logic [REG_NUM_W-1:0] i_r_reg_num_1,
    input  logic [REG_NUM_W-1:0] i_r_reg_num_2,
    output logic                 o_busy_1,
    output logic                 o_busy_2
);
    logic      full0, full1;
    logic      younger0, younger1;
    wb_entry_t entry0, entry1;
    logic      match0_1, match0_2, match1_1, match1_2;
    logic      last_req1;
    grant_e    gnt;
    logic      grant0, grant1;
    logic      out_match_1, out_match_2;

    always_comb begin
        gnt = pick_grant(full0, full1, entry0.reg_num == entry1.reg_num,
                         younger0, younger1, last_req1);
    end

    assign grant0 = (gnt == GNT_REQ0);
    assign grant1 = (gnt == GNT_REQ1);

    wb_slot u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (i_req0_valid),
        .req_reg_num (i_req0_reg_num),
        .req_val     (i_req0_val),
        .req_ready   (o_req0_ready),
        .grant       (grant0),
        .peer_hold   (full1 && !grant1),
        .peer_grant  (grant1),
        .full        (full0),
        .entry       (entry0),
        .younger     (younger0),
        .query_a     (i_r_reg_num_1),
        .query_b     (i_r_reg_num_2),
        .match_a     (match0_1),
        .match_b     (match0_2)
    );

    wb_slot u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (i_req1_valid),
        .req_reg_num (i_req1_reg_num),
        .req_val     (i_req1_val),
        .req_ready   (o_req1_ready),
        .grant       (grant1),
        .peer_hold   (full0 && !grant0),
        .peer_grant  (grant0),
        .full        (full1),
        .entry       (entry1),
        .younger     (younger1),
        .query_a     (i_r_reg_num_1),
        .query_b     (i_r_reg_num_2),
        .match_a     (match1_1),
        .match_b     (match1_2)
    );

    // Reset leaves the pointer as if req1 went last, so req0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_w_en      <= 1'b0;
            o_w_reg_num <= '0;
            o_w_val     <= '0;
            last_req1   <= 1'b1;
        end else begin
            o_w_en <= grant0 || grant1;
            if (grant0) begin
                o_w_reg_num <= entry0.reg_num;
                o_w_val     <= entry0.val;
                last_req1   <= 1'b0;
            end else if (grant1) begin
                o_w_reg_num <= entry1.reg_num;
                o_w_val     <= entry1.val;
                last_req1   <= 1'b1;
            end
        end
    end

    assign out_match_1 = o_w_en && (i_r_reg_num_1 != '0) && (o_w_reg_num == i_r_reg_num_1);
    assign out_match_2 = o_w_en && (i_r_reg_num_2 != '0) && (o_w_reg_num == i_r_reg_num_2);

    assign o_busy_1 = match0_1 || match1_1 || out_match_1;
    assign o_busy_2 = match0_2 || match1_2 || out_match_2;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: expected writes queue up as stimulus is
// driven and are popped when o_w_en is seen; a small register-file model tracks writes.
module tb_regfile_write_arbiter;
    logic        clk;
    logic        rst;
    logic        i_req0_valid, i_req1_valid;
    logic [4:0]  i_req0_reg_num, i_req1_reg_num;
    logic [31:0] i_req0_val, i_req1_val;
    logic        o_req0_ready, o_req1_ready;
    logic        o_w_en;
    logic [4:0]  o_w_reg_num;
    logic [31:0] o_w_val;
    logic [4:0]  i_r_reg_num_1, i_r_reg_num_2;
    logic        o_busy_1, o_busy_2;

    typedef struct packed {
        logic [4:0]  reg_num;
        logic [31:0] val;
    } wr_t;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        first1;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        tbl[10];
    logic [31:0] rf[32];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_exp;
    int          a0, a1, t;
    logic        acc0, acc1;

    regfile_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req0_valid   (i_req0_valid),
        .i_req0_reg_num (i_req0_reg_num),
        .i_req0_val     (i_req0_val),
        .o_req0_ready   (o_req0_ready),
        .i_req1_valid   (i_req1_valid),
        .i_req1_reg_num (i_req1_reg_num),
        .i_req1_val     (i_req1_val),
        .o_req1_ready   (o_req1_ready),
        .o_w_en         (o_w_en),
        .o_w_reg_num    (o_w_reg_num),
        .o_w_val        (o_w_val),
        .i_r_reg_num_1  (i_r_reg_num_1),
        .i_r_reg_num_2  (i_r_reg_num_2),
        .o_busy_1       (o_busy_1),
        .o_busy_2       (o_busy_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input logic v, input logic [4:0] r, input logic [31:0] d);
        if (v && r != 5'd0) begin
            exp_q.push_back({r, d});
            n_exp++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_w_en) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("w_reg_num", 32'(o_w_reg_num), 32'(mon_e.reg_num));
                check("w_val", o_w_val, mon_e.val);
            end
            rf[o_w_reg_num] <= o_w_val;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 5'd1,  32'd100,        1'b1, 5'd2,  32'd200,        1'b0};
        tbl[1] = '{1'b1, 5'd9,  32'h9,          1'b0, 5'd0,  32'h0,          1'b0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd10, 32'hA0,         1'b0};
        tbl[3] = '{1'b1, 5'd4,  32'd44,         1'b1, 5'd6,  32'd66,         1'b0};
        tbl[4] = '{1'b1, 5'd0,  32'h55,         1'b1, 5'd12, 32'hC,          1'b0};
        tbl[5] = '{1'b1, 5'd13, 32'hD,          1'b1, 5'd0,  32'h66,         1'b0};
        tbl[6] = '{1'b1, 5'd14, 32'hE1,         1'b1, 5'd15, 32'hF1,         1'b1};
        tbl[7] = '{1'b1, 5'd20, 32'hAAAA,       1'b1, 5'd20, 32'hBBBB,       1'b0};
        tbl[8] = '{1'b1, 5'd31, 32'hDEADBEEF,   1'b1, 5'd1,  32'h12345678,   1'b0};
        tbl[9] = '{1'b1, 5'd0,  32'h1,          1'b1, 5'd0,  32'h2,          1'b0};

        rst = 1'b0;
        i_req0_valid = 1'b0; i_req0_reg_num = '0; i_req0_val = '0;
        i_req1_valid = 1'b0; i_req1_reg_num = '0; i_req1_val = '0;
        i_r_reg_num_1 = '0; i_r_reg_num_2 = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_w_en", 32'(o_w_en), 32'd0);
        check("rst_w_reg", 32'(o_w_reg_num), 32'd0);
        check("rst_w_val", o_w_val, 32'd0);
        check("rst_rdy0", 32'(o_req0_ready), 32'd1);
        check("rst_rdy1", 32'(o_req1_ready), 32'd1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single uncontended write: accepted at edge E, visible after E+1.
        i_req0_valid = 1'b1; i_req0_reg_num = 5'd3; i_req0_val = 32'hA;
        i_r_reg_num_1 = 5'd3;
        tick();
        i_req0_valid = 1'b0;
        exp_q.push_back({5'd3, 32'hA});
        check("single_wen_early", 32'(o_w_en), 32'd0);
        check("single_busy", 32'(o_busy_1), 32'd1);
        tick();
        check("single_wen", 32'(o_w_en), 32'd1);
        check("single_reg", 32'(o_w_reg_num), 32'd3);
        check("single_val", o_w_val, 32'hA);
        tick();
        check("single_wen_drop", 32'(o_w_en), 32'd0);
        check("single_reg_hold", 32'(o_w_reg_num), 32'd3);
        check("single_val_hold", o_w_val, 32'hA);
        check("single_busy_clr", 32'(o_busy_1), 32'd0);

        // Hazard window on reg 7 while query 2 watches an idle register.
        i_req0_valid = 1'b1; i_req0_reg_num = 5'd7; i_req0_val = 32'h77;
        i_r_reg_num_1 = 5'd7; i_r_reg_num_2 = 5'd8;
        tick();
        i_req0_valid = 1'b0;
        exp_q.push_back({5'd7, 32'h77});
        check("haz_busy1_slot", 32'(o_busy_1), 32'd1);
        check("haz_busy2_slot", 32'(o_busy_2), 32'd0);
        tick();
        check("haz_wen", 32'(o_w_en), 32'd1);
        check("haz_busy1_out", 32'(o_busy_1), 32'd1);
        check("haz_busy2_out", 32'(o_busy_2), 32'd0);
        tick();
        check("haz_busy1_done", 32'(o_busy_1), 32'd0);

        // Register 0 is accepted but never written.
        i_req1_valid = 1'b1; i_req1_reg_num = 5'd0; i_req1_val = 32'hFFFFFFFF;
        i_r_reg_num_1 = 5'd0; i_r_reg_num_2 = 5'd0;
        check("r0_ready", 32'(o_req1_ready), 32'd1);
        tick();
        i_req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("r0_no_wen", 32'(o_w_en), 32'd0);
            check("r0_busy1", 32'(o_busy_1), 32'd0);
            check("r0_busy2", 32'(o_busy_2), 32'd0);
            tick();
        end
        check("r0_ready_after", 32'(o_req1_ready), 32'd1);

        // Same register captured on the same edge: req0 first, req1 lands last.
        i_req0_valid = 1'b1; i_req0_reg_num = 5'd5; i_req0_val = 32'h11;
        i_req1_valid = 1'b1; i_req1_reg_num = 5'd5; i_req1_val = 32'h22;
        tick();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        exp_q.push_back({5'd5, 32'h11});
        exp_q.push_back({5'd5, 32'h22});
        repeat (3) tick();
        check("same_drain", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 10; i++) begin
            i_req0_valid = tbl[i].v0; i_req0_reg_num = tbl[i].r0; i_req0_val = tbl[i].d0;
            i_req1_valid = tbl[i].v1; i_req1_reg_num = tbl[i].r1; i_req1_val = tbl[i].d1;
            check("tbl_rdy0", 32'(o_req0_ready), 32'd1);
            check("tbl_rdy1", 32'(o_req1_ready), 32'd1);
            tick();
            i_req0_valid = 1'b0; i_req1_valid = 1'b0;
            n_exp = 0;
            if (tbl[i].first1) begin
                push_if(tbl[i].v1, tbl[i].r1, tbl[i].d1);
                push_if(tbl[i].v0, tbl[i].r0, tbl[i].d0);
            end else begin
                push_if(tbl[i].v0, tbl[i].r0, tbl[i].d0);
                push_if(tbl[i].v1, tbl[i].r1, tbl[i].d1);
            end
            repeat (n_exp + 1) tick();
            check("tbl_drain", 32'(exp_q.size()), 32'd0);
            check("tbl_idle", 32'(o_w_en), 32'd0);
        end

        // Both requesters stream with fresh values; writes must alternate with no gaps.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({5'd1, 32'(10 + k)});
            exp_q.push_back({5'd2, 32'(20 + k)});
        end
        i_req0_reg_num = 5'd1; i_req1_reg_num = 5'd2;
        a0 = 0; a1 = 0; t = 0;
        do begin
            i_req0_valid = (a0 < 4); i_req0_val = 32'(10 + a0);
            i_req1_valid = (a1 < 4); i_req1_val = 32'(20 + a1);
            acc0 = i_req0_valid && o_req0_ready;
            acc1 = i_req1_valid && o_req1_ready;
            tick();
            t++;
            if (acc0) a0++;
            if (acc1) a1++;
        end while (!(a0 == 4 && a1 == 4 && exp_q.size() == 0) && t < 40);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        check("stream_cycles", 32'(t), 32'd10);
        check("stream_drain", 32'(exp_q.size()), 32'd0);

        // Reset while one write is on the port and the other slot still holds data.
        i_req0_valid = 1'b1; i_req0_reg_num = 5'd16; i_req0_val = 32'h16;
        i_req1_valid = 1'b1; i_req1_reg_num = 5'd17; i_req1_val = 32'h17;
        i_r_reg_num_1 = 5'd16; i_r_reg_num_2 = 5'd17;
        tick();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        exp_q.push_back({5'd16, 32'h16});
        tick();
        check("mid_pre_wen", 32'(o_w_en), 32'd1);
        check("mid_pre_busy1", 32'(o_busy_1), 32'd1);
        check("mid_pre_busy2", 32'(o_busy_2), 32'd1);
        void'(exp_q.pop_back());
        rst = 1'b1;
        #1;
        check("mid_rst_wen", 32'(o_w_en), 32'd0);
        check("mid_rst_reg", 32'(o_w_reg_num), 32'd0);
        check("mid_rst_val", o_w_val, 32'd0);
        check("mid_rst_rdy0", 32'(o_req0_ready), 32'd1);
        check("mid_rst_rdy1", 32'(o_req1_ready), 32'd1);
        check("mid_rst_busy1", 32'(o_busy_1), 32'd0);
        check("mid_rst_busy2", 32'(o_busy_2), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_wen", 32'(o_w_en), 32'd0);
        end
        i_req0_valid = 1'b1; i_req0_reg_num = 5'd18; i_req0_val = 32'h18;
        i_req1_valid = 1'b1; i_req1_reg_num = 5'd19; i_req1_val = 32'h19;
        tick();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        exp_q.push_back({5'd18, 32'h18});
        exp_q.push_back({5'd19, 32'h19});
        tick();
        check("post_rst_first_reg", 32'(o_w_reg_num), 32'd18);
        repeat (2) tick();
        check("post_rst_drain", 32'(exp_q.size()), 32'd0);

        check("rf_reg3", rf[3], 32'd10);
        check("rf_reg5", rf[5], 32'h22);
        check("rf_reg20", rf[20], 32'hBBBB);
        check("rf_reg1", rf[1], 32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
